// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - parametrised VGA horizontal/vertical timing generator
module vga_timing_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CNT_W      = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               enable,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic               line_wrap;
  logic               frame_wrap;
  logic [CNT_W-1:0]   h_next;
  logic [CNT_W-1:0]   v_next;
  logic [FRAME_W-1:0] frame_next;
  logic               hsync_next;
  logic               vsync_next;
  logic               display_next;
  logic               line_end_next;
  logic               frame_end_next;

  // Next-state counts and the decodes of that next position, so registered
  // decodes line up with the registered counts without skew. The >= tests
  // pull any out-of-range count back to 0 on the next enabled edge.
  always_comb begin
    line_wrap  = (h_count >= H_LAST);
    frame_wrap = line_wrap && (v_count >= V_LAST);
    h_next     = line_wrap ? '0 : h_count + 1'b1;
    if (v_count > V_LAST) begin
      v_next = '0;
    end else if (line_wrap) begin
      v_next = (v_count >= V_LAST) ? '0 : v_count + 1'b1;
    end else begin
      v_next = v_count;
    end
    frame_next     = frame_wrap ? frame_count + 1'b1 : frame_count;
    hsync_next     = ((h_next >= HS_START) && (h_next < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_next     = ((v_next >= VS_START) && (v_next < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    display_next   = (h_next < H_ACT_END) && (v_next < V_ACT_END);
    line_end_next  = (h_next == H_LAST);
    frame_end_next = (h_next == H_LAST) && (v_next == V_LAST);
  end

  // Output registers; everything holds while enable is low, strobes included.
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      hsync       <= ~H_SYNC_POL;
      vsync       <= ~V_SYNC_POL;
      display_on  <= 1'b1;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
    end else if (enable) begin
      h_count     <= h_next;
      v_count     <= v_next;
      frame_count <= frame_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      display_on  <= display_next;
      line_end    <= line_end_next;
      frame_end   <= frame_end_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - self-checking bench for vga_timing_generator
module tb_vga_timing_generator;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        de;
    logic        le;
    logic        fe;
    logic [7:0]  fc;
  } out_t;

  logic       pixel_clk = 1'b0;
  logic       reset     = 1'b0;
  logic       enable    = 1'b0;

  logic [9:0] h_a, v_a, h_b, v_b;
  logic       hs_a, vs_a, de_a, le_a, fe_a;
  logic       hs_b, vs_b, de_b, le_b, fe_b;
  logic [7:0] fc_a;
  logic [1:0] fc_b;

  int  checks = 0;
  int  errors = 0;
  longint n   = 0;

  out_t got, want;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_generator dut_a (
    .pixel_clk(pixel_clk), .reset(reset), .enable(enable),
    .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .line_end(le_a), .frame_end(fe_a), .frame_count(fc_a)
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .FRAME_W(2)
  ) dut_b (
    .pixel_clk(pixel_clk), .reset(reset), .enable(enable),
    .h_count(h_b), .v_count(v_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .line_end(le_b), .frame_end(fe_b), .frame_count(fc_b)
  );

  // Reference: position after n enabled edges, from plain division/modulo.
  function automatic out_t model(input longint cnt, input int ha, hf, hsw, hb,
                                 input int va, vf, vsw, vb, input bit hp, vp, input int fw);
    out_t o;
    longint ht, vt, h, line, v, fr;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    h    = cnt % ht;
    line = cnt / ht;
    v    = line % vt;
    fr   = (line / vt) % (64'd1 << fw);
    o.h  = 16'(h);
    o.v  = 16'(v);
    o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.de = (h < ha) && (v < va);
    o.le = (h == ht - 1);
    o.fe = (h == ht - 1) && (v == vt - 1);
    o.fc = 8'(fr);
    return o;
  endfunction

  function automatic out_t exp_a(input longint cnt);
    return model(cnt, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
  endfunction

  function automatic out_t exp_b(input longint cnt);
    return model(cnt, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);
  endfunction

  function automatic out_t obs_a();
    return {6'd0, h_a, 6'd0, v_a, hs_a, vs_a, de_a, le_a, fe_a, fc_a};
  endfunction

  function automatic out_t obs_b();
    return {6'd0, h_b, 6'd0, v_b, hs_b, vs_b, de_b, le_b, fe_b, 6'd0, fc_b};
  endfunction

  // One clock: drive enable at the falling edge, sample at the next falling edge.
  task automatic tick(input bit en);
    enable = en;
    @(posedge pixel_clk);
    if (en) n++;
    @(negedge pixel_clk);
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge pixel_clk);
    reset = 1'b1;
    n     = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge pixel_clk);
    got = obs_a(); want = exp_a(0); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_a got %h exp %h", got, want); end
    got = obs_b(); want = exp_b(0); checks++;
    if (got !== want) begin errors++; $display("FAIL reset_b got %h exp %h", got, want); end
    reset = 1'b1;
    n = 0;
  endtask

  task automatic test_line();
    do_reset();
    for (int i = 0; i < 1602; i++) begin
      tick(1'b1);
      got = obs_a(); want = exp_a(n); checks++;
      if (got !== want) begin errors++; $display("FAIL line_a n=%0d got %h exp %h", n, got, want); end
      got = obs_b(); want = exp_b(n); checks++;
      if (got !== want) begin errors++; $display("FAIL line_b n=%0d got %h exp %h", n, got, want); end
    end
  endtask

  task automatic test_small_frames();
    int fe_seen;
    int de_seen;
    fe_seen = 0;
    de_seen = 0;
    do_reset();
    for (int i = 0; i < 4 * 48 + 1; i++) begin
      tick(1'b1);
      if (fe_b) fe_seen++;
      if (de_b && i < 48) de_seen++;
      got = obs_b(); want = exp_b(n); checks++;
      if (got !== want) begin errors++; $display("FAIL frames_b n=%0d got %h exp %h", n, got, want); end
    end
    checks++;
    if (fe_seen != 4) begin errors++; $display("FAIL frame_end_count got %0d exp 4", fe_seen); end
    checks++;
    if (de_seen != 12) begin errors++; $display("FAIL display_on_count got %0d exp 12", de_seen); end
    checks++;
    if (fc_b !== 2'd0) begin errors++; $display("FAIL frame_wrap got %0d exp 0", fc_b); end
  endtask

  task automatic test_random_enable();
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      tick(1'($urandom_range(0, 1)));
      got = obs_a(); want = exp_a(n); checks++;
      if (got !== want) begin errors++; $display("FAIL rand_a n=%0d got %h exp %h", n, got, want); end
      got = obs_b(); want = exp_b(n); checks++;
      if (got !== want) begin errors++; $display("FAIL rand_b n=%0d got %h exp %h", n, got, want); end
    end
  endtask

  task automatic test_hold_strobes();
    do_reset();
    for (int i = 0; i < 799; i++) tick(1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      checks++;
      if (le_a !== 1'b1) begin errors++; $display("FAIL hold_line_end got %b exp 1", le_a); end
      got = obs_a(); want = exp_a(n); checks++;
      if (got !== want) begin errors++; $display("FAIL hold_a got %h exp %h", got, want); end
    end
    tick(1'b1);
    got = obs_a(); want = exp_a(n); checks++;
    if (got !== want) begin errors++; $display("FAIL hold_resume got %h exp %h", got, want); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      do_reset();
      for (int i = 0; i < int'($urandom_range(100, 900)); i++) tick(1'b1);
      enable = 1'b1;
      @(posedge pixel_clk);
      n++;
      #2 reset = 1'b0;
      #1;
      got = obs_a(); want = exp_a(0); checks++;
      if (got !== want) begin errors++; $display("FAIL async_a got %h exp %h", got, want); end
      got = obs_b(); want = exp_b(0); checks++;
      if (got !== want) begin errors++; $display("FAIL async_b got %h exp %h", got, want); end
      repeat (3) @(negedge pixel_clk);
      got = obs_a(); checks++;
      if (got !== want && got !== exp_a(0)) begin errors++; $display("FAIL async_hold got %h exp %h", got, exp_a(0)); end
      reset = 1'b1;
      n = 0;
      tick(1'b1);
      checks++;
      if (h_a !== 10'd1) begin errors++; $display("FAIL async_first_edge got %0d exp 1", h_a); end
      got = obs_b(); want = exp_b(n); checks++;
      if (got !== want) begin errors++; $display("FAIL async_first_b got %h exp %h", got, want); end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_small_frames();
    test_random_enable();
    test_hold_strobes();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the single-axis VGA counters. Generates horizontal and vertical pixel counts, sync pulses, an active-video flag and line/frame strobes for one display mode.
- Sits between the pixel clock source and the sprite/background renderers.
- Porch, sync and active widths, sync polarity and frame-counter width are all set by parameter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level (0 = active-low)
- CNT_W, 10, width of h_count/v_count; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, width of frame_count

Ports:
- pixel_clk  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- enable  input  1  pixel-clock enable; counters advance only when high
- h_count  output  CNT_W  current pixel column, 0..H_TOTAL-1
- v_count  output  CNT_W  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity per H_SYNC_POL
- vsync  output  1  vertical sync, polarity per V_SYNC_POL
- display_on  output  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE
- line_end  output  1  one-cycle strobe on the last pixel of each line
- frame_end  output  1  one-cycle strobe on the last pixel of each frame
- frame_count  output  FRAME_W  completed-frame counter, wraps

Behaviour:
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default)
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525 by default)
- Reset (reset = 0, asynchronous, any time including mid-frame):
  - h_count = 0, v_count = 0, frame_count = 0.
  - line_end = 0, frame_end = 0, display_on = 1 (position 0,0 is active).
  - hsync and vsync at their deasserted levels (~H_SYNC_POL, ~V_SYNC_POL).
  - Counting resumes on the first pixel_clk rising edge with reset = 1 and enable = 1.
- All outputs are registered.
- hsync, vsync, display_on, line_end and frame_end are decoded from the next-state counts and registered alongside them. They therefore describe the current h_count/v_count with zero cycles of skew.
- On each rising edge with enable = 1:
  - h_count increments. At H_TOTAL-1 it wraps to 0 and v_count advances.
  - v_count increments per line. At V_TOTAL-1 with h_count = H_TOTAL-1, v_count wraps to 0 and frame_count increments modulo 2^FRAME_W.
- With enable = 0, every output holds its value, including the strobes. A strobe stays high until the next enabled edge, so consumers must qualify strobes with enable.
- Counts never exceed their total-1. An out-of-range value (e.g. after a glitch) forces a wrap to 0 on the next enabled edge: use >= comparisons.
- Decodes:
  - hsync is asserted while H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC (656..751 by default).
  - vsync is asserted while V_ACTIVE+V_FRONT <= v_count < V_ACTIVE+V_FRONT+V_SYNC (490..491). vsync changes on line boundaries, aligned with h_count = 0.
  - line_end = 1 exactly when h_count = H_TOTAL-1.
  - frame_end = 1 exactly when h_count = H_TOTAL-1 and v_count = V_TOTAL-1; line_end is also high then.
- No combinational path from enable to any output.

Test Plan:
- Release reset, enable held at 1, run 800 cycles:
  - h_count goes 0..799 then 0; v_count goes 0 to 1 on that wrap.
  - line_end is high only at h_count = 799.
  - hsync is low for h_count 656..751 and high elsewhere.
- Run one full frame (420,000 enabled cycles):
  - frame_end pulses once, at (799,524); frame_count goes 0 to 1.
  - vsync is low only for v_count 490..491.
  - display_on is high for 640×480 = 307,200 cycles.
- Toggle enable at 50% duty:
  - Counts advance only on enabled edges; all outputs hold while enable is low.
  - A frame takes 840,000 clocks.
- Assert reset asynchronously mid-frame at (300,200), between clock edges:
  - All outputs return to reset values immediately.
  - After release, the first enabled edge gives h_count = 1.
- Parameter override H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1, V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1, H_SYNC_POL=1, V_SYNC_POL=1, FRAME_W=2:
  - Lines are 8 pixels, frames 6 lines.
  - hsync is high at h_count 5..6; vsync is high at v_count 4.
  - frame_count wraps 3 to 0 after 4 frames.
